parking_gate_controller: RTL and testbench
==========================================

PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 SHALL have parameter CAPACITY, default 8, number of parking spots (legal 1..15).
REQ-002 SHALL have parameter OPEN_TICKS, default 15000000, maximum clk cycles a barrier stays open awaiting a car.
REQ-003 SHALL have parameter GUARD_TICKS, default 4, closed-barrier cycles enforced between services.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port entry_sensor  input  1  car waiting at entry lane (level, clk-synchronous).
REQ-007 SHALL have port exit_sensor  input  1  car waiting at exit lane (level, clk-synchronous).
REQ-008 SHALL have port pass_sensor  input  1  car has cleared the shared barrier (level).
REQ-009 SHALL have port entry_gate  output  1  open command, entry direction of the shared barrier.
REQ-010 SHALL have port exit_gate  output  1  open command, exit direction of the shared barrier.
REQ-011 SHALL have port occupancy  output  4  cars currently parked.
REQ-012 SHALL have port next_full  output  1  high when occupancy == CAPACITY; feeds the lot-full indicator logic.
REQ-013 SHALL have port entry_denied  output  1  one-cycle pulse when an entry request is rejected because the lot is full.

Function
REQ-014 SHALL detect requests on rising edges only: a sensor's registered previous value is low and its current value is high at a clk edge.
REQ-015 SHALL latch each detected edge into a pending flag (entry_pend, exit_pend) at that edge; repeated edges while pending SHALL be absorbed.
REQ-016 SHALL implement FSM states IDLE, ENTRY_OPEN, EXIT_OPEN, GUARD; exactly one of entry_gate/exit_gate high in the matching OPEN state, both low otherwise.
REQ-017 In IDLE with exit_pend set and occupancy > 0, SHALL move to EXIT_OPEN and clear exit_pend (exit has priority over entry).
REQ-018 In IDLE with exit_pend set and occupancy == 0, SHALL clear exit_pend and stay in IDLE.
REQ-019 In IDLE with only entry_pend set and next_full low, SHALL move to ENTRY_OPEN and clear entry_pend.
REQ-020 In IDLE with only entry_pend set and next_full high, SHALL clear entry_pend, pulse entry_denied for exactly one cycle, remain in IDLE.
REQ-021 Gate output SHALL be registered: a sensor sampled high at edge k (low at k-1) from IDLE with no competing request yields gate high after edge k+1.
REQ-022 In an OPEN state, a 26-bit timer SHALL count from 0 each cycle; pass_sensor high SHALL close the gate and enter GUARD at that edge.
REQ-023 On pass_sensor in ENTRY_OPEN occupancy SHALL increment by 1; in EXIT_OPEN it SHALL decrement by 1, in the same edge as the close.
REQ-024 If timer reaches OPEN_TICKS-1 without pass_sensor, SHALL close and enter GUARD with occupancy unchanged; pass_sensor on that same cycle SHALL count as a pass.
REQ-025 GUARD SHALL last exactly GUARD_TICKS cycles, then return to IDLE; requests arriving during OPEN or GUARD SHALL stay pending.
REQ-026 occupancy SHALL never exceed CAPACITY nor go below 0; next_full SHALL be combinational from occupancy.
REQ-027 pass_sensor in IDLE or GUARD SHALL be ignored.

Reset
REQ-028 On rst high, asynchronously: state IDLE, timers 0, pending flags 0, sensor history 0, occupancy 0, entry_gate 0, exit_gate 0, entry_denied 0, next_full 0.
REQ-029 Reset asserted mid-service SHALL drop the gate immediately and discard the in-flight pass; a sensor held high across reset release SHALL register as one request.

Verification (CAPACITY=2, OPEN_TICKS=10, GUARD_TICKS=2)
REQ-030 Entry rise, pass 3 cycles later -> entry_gate high after 2nd edge, low on pass edge, occupancy 0->1, GUARD 2 cycles.
REQ-031 Two entries to occupancy 2, third entry rise -> next_full 1, entry_denied single-cycle pulse, entry_gate stays 0.
REQ-032 Entry and exit rise same cycle at occupancy 1 -> exit served first (occupancy 0), then entry after GUARD (occupancy 1).
REQ-033 Entry rise, no pass -> entry_gate high exactly 10 cycles, closes, occupancy unchanged.
REQ-034 Exit rise at occupancy 0 -> exit_gate never asserts, exit_pend cleared.
REQ-035 rst pulse while exit_gate high -> exit_gate 0 asynchronously, occupancy 0, state IDLE.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Shared entry/exit barrier controller: rising-edge request capture, exit-priority
// arbitration, open timeout, post-service guard interval and occupancy tracking.
module parking_gate_controller #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned OPEN_TICKS  = 15000000,
    parameter int unsigned GUARD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    input  logic       pass_sensor,
    output logic       entry_gate,
    output logic       exit_gate,
    output logic [3:0] occupancy,
    output logic       next_full,
    output logic       entry_denied
);

    localparam logic [25:0] OPEN_LAST  = 26'(OPEN_TICKS - 1);
    localparam logic [25:0] GUARD_LAST = 26'(GUARD_TICKS - 1);
    localparam logic [3:0]  CAP        = 4'(CAPACITY);

    typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN, GUARD} state_t;

    state_t      state;
    logic [25:0] timer;
    logic        entry_prev, exit_prev;
    logic        entry_pend, exit_pend;
    logic        entry_rise, exit_rise;
    logic        entry_clr, exit_clr;

    assign entry_rise = entry_sensor & ~entry_prev;
    assign exit_rise  = exit_sensor & ~exit_prev;
    assign next_full  = (occupancy == CAP);

    // A fresh rising edge on the clearing cycle is a new request, so set wins.
    always_comb begin
        exit_clr  = (state == IDLE) && exit_pend;
        entry_clr = (state == IDLE) && !exit_pend && entry_pend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            entry_prev   <= 1'b0;
            exit_prev    <= 1'b0;
            entry_pend   <= 1'b0;
            exit_pend    <= 1'b0;
            occupancy    <= '0;
            entry_gate   <= 1'b0;
            exit_gate    <= 1'b0;
            entry_denied <= 1'b0;
        end else begin
            entry_prev   <= entry_sensor;
            exit_prev    <= exit_sensor;
            entry_pend   <= entry_rise | (entry_pend & ~entry_clr);
            exit_pend    <= exit_rise | (exit_pend & ~exit_clr);
            entry_denied <= 1'b0;
            case (state)
                IDLE: begin
                    if (exit_pend) begin
                        if (occupancy != '0) begin
                            state     <= EXIT_OPEN;
                            exit_gate <= 1'b1;
                            timer     <= '0;
                        end
                    end else if (entry_pend) begin
                        if (next_full) begin
                            entry_denied <= 1'b1;
                        end else begin
                            state      <= ENTRY_OPEN;
                            entry_gate <= 1'b1;
                            timer      <= '0;
                        end
                    end
                end
                ENTRY_OPEN, EXIT_OPEN: begin
                    if (pass_sensor || timer == OPEN_LAST) begin
                        state      <= GUARD;
                        entry_gate <= 1'b0;
                        exit_gate  <= 1'b0;
                        timer      <= '0;
                        if (pass_sensor) begin
                            if (state == ENTRY_OPEN && occupancy != CAP)
                                occupancy <= occupancy + 4'd1;
                            else if (state == EXIT_OPEN && occupancy != '0)
                                occupancy <= occupancy - 4'd1;
                        end
                    end else begin
                        timer <= timer + 26'd1;
                    end
                end
                GUARD: begin
                    if (timer == GUARD_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 26'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed scenarios and random traffic compared
// against a behavioural model of the barrier (direction, age, guard countdown, car count).
module tb_parking_gate_controller;

    localparam int CAP = 2;
    localparam int OT  = 10;
    localparam int GT  = 2;

    logic       clk = 1'b0;
    logic       rst, es, xs, ps;
    logic       entry_gate, exit_gate, next_full, entry_denied;
    logic [3:0] occupancy;
    logic [7:0] obs;

    parking_gate_controller #(.CAPACITY(CAP), .OPEN_TICKS(OT), .GUARD_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .entry_sensor(es), .exit_sensor(xs), .pass_sensor(ps),
        .entry_gate(entry_gate), .exit_gate(exit_gate), .occupancy(occupancy),
        .next_full(next_full), .entry_denied(entry_denied)
    );

    always #5 clk = ~clk;
    assign obs = {entry_gate, exit_gate, entry_denied, next_full, occupancy};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: dir = +1 barrier open inward, -1 open outward, 0 closed.
    int m_occ, m_dir, m_age, m_guard;
    bit m_ep, m_xp, m_pe, m_px, m_den;

    function automatic logic [7:0] expv();
        return {m_dir == 1, m_dir == -1, m_den, m_occ == CAP, 4'(m_occ)};
    endfunction

    task automatic model_reset();
        m_occ = 0; m_dir = 0; m_age = 0; m_guard = 0;
        m_ep = 0; m_xp = 0; m_pe = 0; m_px = 0; m_den = 0;
    endtask

    task automatic model_step();
        bit re, rx, ce, cx;
        re = es && !m_pe;
        rx = xs && !m_px;
        ce = 0; cx = 0;
        m_den = 0;
        if (m_dir == 0 && m_guard == 0) begin
            if (m_xp) begin
                cx = 1;
                if (m_occ > 0) begin m_dir = -1; m_age = 0; end
            end else if (m_ep) begin
                ce = 1;
                if (m_occ == CAP) m_den = 1;
                else begin m_dir = 1; m_age = 0; end
            end
        end else if (m_dir != 0) begin
            if (ps || m_age == OT - 1) begin
                if (ps) begin
                    m_occ = m_occ + m_dir;
                    if (m_occ > CAP) m_occ = CAP;
                    if (m_occ < 0) m_occ = 0;
                end
                m_dir = 0;
                m_guard = GT;
            end else begin
                m_age++;
            end
        end else begin
            m_guard--;
        end
        m_ep = re || (m_ep && !ce);
        m_xp = rx || (m_xp && !cx);
        m_pe = es;
        m_px = xs;
    endtask

    task automatic step(input bit e, input bit x, input bit p);
        @(negedge clk);
        es = e; xs = x; ps = p;
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; es = 0; xs = 0; ps = 0;
        model_reset();
        @(posedge clk);
        #1;
        tests++;
        if (obs !== 8'h00) begin
            fails++;
            $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
        end
        rst = 1'b0;
    endtask

    task automatic test_entry_pass();
        bit [2:0] pat[7] = '{3'b100, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 7; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL entry_pass cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i == 1) begin
                tests++;
                if (entry_gate !== 1'b1) begin
                    fails++;
                    $display("FAIL entry_gate_latency got=%b exp=1", entry_gate);
                end
            end
            if (i == 3) begin
                tests++;
                if ({entry_gate, occupancy} !== {1'b0, 4'd1}) begin
                    fails++;
                    $display("FAIL entry_pass_close got=%b/%0d exp=0/1", entry_gate, occupancy);
                end
            end
        end
    endtask

    task automatic test_full_denied();
        bit [2:0] pat[9] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000,
                             3'b100, 3'b000, 3'b000};
        int den = 0, gate = 0;
        for (int i = 0; i < 9; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            if (i >= 6) begin den += int'(entry_denied); gate += int'(entry_gate); end
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL full_denied cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
        end
        tests++;
        if (den != 1 || gate != 0 || next_full !== 1'b1) begin
            fails++;
            $display("FAIL denied_pulse got den=%0d gate=%0d full=%b exp 1/0/1", den, gate, next_full);
        end
    endtask

    task automatic test_priority();
        bit [2:0] pat[16] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000,
                              3'b110, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000,
                              3'b001, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 16; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL priority cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i == 7) begin
                tests++;
                if ({exit_gate, entry_gate} !== 2'b10) begin
                    fails++;
                    $display("FAIL exit_first got=%b%b exp=10", exit_gate, entry_gate);
                end
            end
        end
        tests++;
        if (occupancy !== 4'd1) begin
            fails++;
            $display("FAIL priority_occ got=%0d exp=1", occupancy);
        end
    endtask

    task automatic test_timeout();
        int open = 0;
        for (int i = 0; i < 16; i++) begin
            step(i == 0, 1'b0, 1'b0);
            open += int'(entry_gate);
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
        end
        tests++;
        if (open != OT || occupancy !== 4'd1) begin
            fails++;
            $display("FAIL timeout_len got=%0d cycles occ=%0d exp=%0d occ=1", open, occupancy, OT);
        end
    endtask

    task automatic test_exit_empty();
        bit [2:0] pat[14] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000,
                              3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b100, 3'b000, 3'b000};
        int xg = 0;
        for (int i = 0; i < 14; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            if (i >= 6) xg += int'(exit_gate);
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL exit_empty cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
        end
        tests++;
        if (xg != 0 || entry_gate !== 1'b1) begin
            fails++;
            $display("FAIL exit_empty_gate got xg=%0d eg=%b exp 0/1", xg, entry_gate);
        end
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, i == 0);
    endtask

    task automatic test_async_reset();
        int served = 0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        tests++;
        if (exit_gate !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_exit got=%b exp=1", exit_gate);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (obs !== expv() || obs !== 8'h00) begin
            fails++;
            $display("FAIL async_reset got=%b exp=%b", obs, 8'h00);
        end
        step(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            served += int'(entry_gate);
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
        end
        tests++;
        if (served != OT) begin
            fails++;
            $display("FAIL held_sensor_once got=%0d open cycles exp=%0d", served, OT);
        end
    endtask

    task automatic test_random();
        bit e = 0, x = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) e = !e;
            if ($urandom_range(0, 4) == 0) x = !x;
            step(e, x, $urandom_range(0, 3) == 0);
            tests++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry_pass();
        test_full_denied();
        test_priority();
        test_timeout();
        test_exit_empty();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
